// File: rtl/dram_resp_model.sv
// DRAM responder: byte-masked word memory with in-order, latency-aged read returns
// and phase-throttled acceptance on the read-address and write channels.
module dram_resp_model #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int LATENCY    = 4,
  parameter int DEPTH      = 4,
  parameter int ACK_PERIOD = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_hold,
  input  logic                       ra_rdy,
  output logic                       ra_ack,
  input  logic [AW-1:0]              ra_addr,
  output logic                       rd_rdy,
  input  logic                       rd_ack,
  output logic [DW-1:0]              rd_data,
  input  logic                       w_rdy,
  output logic                       w_ack,
  input  logic [AW-1:0]              w_addr,
  input  logic [DW-1:0]              w_data,
  input  logic [DW/8-1:0]            w_mask,
  output logic [$clog2(DEPTH+1)-1:0] o_pending,
  output logic [31:0]                o_rd_cnt,
  output logic [31:0]                o_wr_cnt
);

  localparam int MW   = DW / 8;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AGW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PW   = (ACK_PERIOD > 1) ? $clog2(ACK_PERIOD) : 1;

  // Handshake: a transfer happens at a rising edge where rdy && ack are both high;
  // the sender holds rdy and payload stable until it sees ack.

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [DW-1:0]   q_data [DEPTH];
  logic [AGW-1:0]  q_age [DEPTH];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [PW-1:0]   phase;

  logic            ra_xfer;
  logic            rd_xfer;
  logic            w_xfer;
  logic [PTRW-1:0] cand_ptr;
  logic [CW-1:0]   cand_cnt;
  logic            cand_ok;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    next_ptr = (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // A full queue blocks acceptance even when the head is leaving this cycle.
  assign ra_ack  = ra_rdy && !i_rst && !i_hold && (phase == '0) && (o_pending < CW'(DEPTH));
  assign w_ack   = w_rdy && !i_rst && !i_hold && (phase == '0);
  assign ra_xfer = ra_rdy && ra_ack;
  assign rd_xfer = rd_rdy && rd_ack;
  assign w_xfer  = w_rdy && w_ack;

  // Entry that would be presented after this edge: the one behind the head when
  // the head is leaving, otherwise the head itself. Ages are pre-edge values.
  always_comb begin
    cand_ptr = head;
    cand_cnt = o_pending;
    cand_ok  = 1'b0;
    if (rd_xfer) begin
      cand_ptr = next_ptr(head);
      cand_cnt = o_pending - CW'(1);
    end
    cand_ok = (cand_cnt != '0) && (q_age[cand_ptr] == AGW'(LATENCY - 1));
  end

  always_ff @(posedge i_clk) begin
    if (w_xfer) begin
      for (int b = 0; b < MW; b++) begin
        if (w_mask[b]) mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // Memory is read before the same-edge write lands, so a colliding read sees old data.
  always_ff @(posedge i_clk) begin
    if (ra_xfer) q_data[tail] <= mem[ra_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head      <= '0;
      tail      <= '0;
      phase     <= '0;
      o_pending <= '0;
      rd_rdy    <= 1'b0;
      rd_data   <= '0;
      o_rd_cnt  <= '0;
      o_wr_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) q_age[i] <= '0;
    end else begin
      phase <= (phase == PW'(ACK_PERIOD - 1)) ? '0 : phase + PW'(1);

      for (int i = 0; i < DEPTH; i++) begin
        if (q_age[i] != AGW'(LATENCY - 1)) q_age[i] <= q_age[i] + AGW'(1);
      end

      if (ra_xfer) begin
        q_age[tail] <= '0;
        tail        <= next_ptr(tail);
      end
      if (rd_xfer) head <= next_ptr(head);

      o_pending <= o_pending + CW'(ra_xfer) - CW'(rd_xfer);

      // Presented data stays frozen until consumed.
      if (!rd_rdy || rd_ack) begin
        rd_rdy <= cand_ok;
        if (cand_ok) rd_data <= q_data[cand_ptr];
      end

      if (rd_xfer) o_rd_cnt <= o_rd_cnt + 32'd1;
      if (w_xfer)  o_wr_cnt <= o_wr_cnt + 32'd1;
    end
  end

endmodule
